// File: rtl/parking_entry_ctrl.sv
// Entry-side parking controller: car detect, button sync/edge, ticket issue, barrier, occupancy.
// Latency: btn sampled at edge k -> ticket_vld in cycle k+1..k+2 -> gate_open from edge k+2.
// Backpressure: none; new entries are blocked while occupancy equals CAPACITY.
module parking_entry_ctrl #(
    parameter int CAPACITY     = 8,
    parameter int OCC_W        = 4,
    parameter int ID_W         = 8,
    parameter int OPEN_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_in,
    input  logic             btn,
    input  logic             car_pass,
    input  logic             exit_evt,
    output logic             ticket_vld,
    output logic [ID_W-1:0]  ticket_id,
    output logic             gate_open,
    output logic             full,
    output logic [OCC_W-1:0] occupancy,
    output logic [2:0]       state
);

    localparam int TMR_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BTN = 3'd1,
        ISSUE    = 3'd2,
        OPEN     = 3'd3,
        PASS     = 3'd4
    } state_t;

    state_t           st;
    logic             b1, b2;
    logic             btn_rise;
    logic [TMR_W-1:0] timer;
    logic [ID_W-1:0]  tkt_cnt;
    logic             pass_done;
    logic             occ_dec;

    assign btn_rise  = b1 & ~b2;
    assign pass_done = (st == PASS) & ~car_pass;
    assign occ_dec   = exit_evt & (occupancy != '0);
    assign full      = (occupancy == OCC_W'(CAPACITY));
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1 <= 1'b0;
            b2 <= 1'b0;
        end else begin
            b1 <= btn;
            b2 <= b1;
        end
    end

    // Outputs are computed from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            ticket_vld <= 1'b0;
            ticket_id  <= '0;
            gate_open  <= 1'b0;
            timer      <= '0;
            tkt_cnt    <= '0;
        end else begin
            ticket_vld <= 1'b0;
            case (st)
                IDLE: begin
                    gate_open <= 1'b0;
                    if (car_in && !full) st <= WAIT_BTN;
                end
                WAIT_BTN: begin
                    if (!car_in) begin
                        st <= IDLE;
                    end else if (btn_rise) begin
                        st         <= ISSUE;
                        ticket_vld <= 1'b1;
                        ticket_id  <= tkt_cnt;
                    end
                end
                ISSUE: begin
                    st        <= OPEN;
                    tkt_cnt   <= tkt_cnt + 1'b1;
                    timer     <= '0;
                    gate_open <= 1'b1;
                end
                OPEN: begin
                    if (car_pass) begin
                        st <= PASS;
                    end else if (timer == TMR_W'(OPEN_TIMEOUT - 1)) begin
                        st        <= IDLE;
                        gate_open <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PASS: begin
                    if (!car_pass) begin
                        st        <= IDLE;
                        gate_open <= 1'b0;
                    end
                end
                default: begin
                    st        <= IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

    // A completed entry and an exit in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (pass_done && !exit_evt) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (occ_dec && !pass_done) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_parking_entry_ctrl.sv
// Directed bench for parking_entry_ctrl: cycle table for basic entries, then hand sequences.
module tb_parking_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_in = 1'b0, btn = 1'b0, car_pass = 1'b0, exit_evt = 1'b0;
    logic       ticket_vld, gate_open, full;
    logic [7:0] ticket_id;
    logic [3:0] occupancy;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_tid = 8'd0;

    always #5 clk = ~clk;

    parking_entry_ctrl #(.CAPACITY(8), .OCC_W(4), .ID_W(8), .OPEN_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .car_in(car_in), .btn(btn), .car_pass(car_pass),
        .exit_evt(exit_evt), .ticket_vld(ticket_vld), .ticket_id(ticket_id),
        .gate_open(gate_open), .full(full), .occupancy(occupancy), .state(state)
    );

    typedef struct {
        logic       car_in, btn, car_pass, exit_evt;
        logic [2:0] st;
        logic       vld, gate;
        logic [3:0] occ;
        logic [7:0] tid;
    } vec_t;

    vec_t vecs[24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One entry attempt; pass=0 lets the barrier time out, coinc pulses exit_evt on completion.
    task automatic entry(input bit pass, input bit coinc, output int id, output int gcnt);
        int n;
        id = -1;
        gcnt = 0;
        btn = 1'b0; car_in = 1'b1;
        step(); step();
        btn = 1'b1;
        n = 0;
        while (!ticket_vld && n < 10) begin step(); n++; end
        chk("ticket_seen", int'(ticket_vld), 1);
        id = int'(ticket_id);
        step();
        chk("gate_after_issue", int'(gate_open), 1);
        gcnt = 1;
        if (pass) begin
            car_pass = 1'b1;
            step(); step(); step();
            car_pass = 1'b0; exit_evt = coinc;
            step();
            exit_evt = 1'b0;
            chk("pass_gate_closed", int'(gate_open), 0);
            chk("pass_state_idle", int'(state), 0);
        end else begin
            n = 0;
            while (n < 40) begin
                step();
                n++;
                if (gate_open) gcnt++;
                else break;
            end
        end
        car_in = 1'b0; btn = 1'b0;
        step();
    endtask

    initial begin
        int id, gcnt, pulses, n;
        logic [3:0] occ_before;

        //            car btn pas ext  st vld gate occ tid
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd0,8'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd0,8'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 3'd2,1'b1,1'b0,4'd0,8'd0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0, 3'd3,1'b0,1'b1,4'd0,8'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0, 3'd3,1'b0,1'b1,4'd0,8'd0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,4'd0,8'd0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,4'd0,8'd0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd1,8'd0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd1,8'd0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd1,8'd0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 3'd2,1'b1,1'b0,4'd1,8'd1};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0, 3'd3,1'b0,1'b1,4'd1,8'd0};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,4'd1,8'd0};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd2,8'd0};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd2,8'd0};
        vecs[15] = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd2,8'd0};
        vecs[16] = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd2,8'd0};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd2,8'd0};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd2,8'd0};
        vecs[19] = '{1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,4'd2,8'd0};
        vecs[20] = '{1'b0,1'b1,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd2,8'd0};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd2,8'd0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b1, 3'd0,1'b0,1'b0,4'd1,8'd0};
        vecs[23] = '{1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b0,4'd1,8'd0};

        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_gate", int'(gate_open), 0);
        chk("rst_vld", int'(ticket_vld), 0);
        chk("rst_tid", int'(ticket_id), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_full", int'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 24; i++) begin
            car_in = vecs[i].car_in; btn = vecs[i].btn;
            car_pass = vecs[i].car_pass; exit_evt = vecs[i].exit_evt;
            step();
            chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            chk($sformatf("vec%0d_vld", i), int'(ticket_vld), int'(vecs[i].vld));
            chk($sformatf("vec%0d_gate", i), int'(gate_open), int'(vecs[i].gate));
            chk($sformatf("vec%0d_occ", i), int'(occupancy), int'(vecs[i].occ));
            if (vecs[i].vld) chk($sformatf("vec%0d_tid", i), int'(ticket_id), int'(vecs[i].tid));
        end
        exp_tid = 8'd2;

        // Bouncy button: only the first edge seen in WAIT_BTN issues a ticket.
        car_in = 1'b1; btn = 1'b0;
        step();
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            btn = (i < 4) ? logic'(i % 2) : 1'b1;
            step();
            if (ticket_vld) begin
                pulses++;
                chk("bounce_tid", int'(ticket_id), int'(exp_tid));
            end
        end
        exp_tid++;
        chk("bounce_pulses", pulses, 1);
        chk("bounce_state_wait", int'(state), 1);
        chk("bounce_occ", int'(occupancy), 1);
        car_in = 1'b0; btn = 1'b0;
        step();

        // Timeout: gate open exactly 16 cycles, occupancy unchanged.
        entry(1'b0, 1'b0, id, gcnt);
        chk("timeout_tid", id, int'(exp_tid));
        exp_tid++;
        chk("timeout_gate_cycles", gcnt, 16);
        chk("timeout_occ", int'(occupancy), 1);

        // Fill the lot.
        n = 0;
        while (occupancy < 4'd8 && n < 10) begin
            entry(1'b1, 1'b0, id, gcnt);
            chk("fill_tid", id, int'(exp_tid));
            exp_tid++;
            n++;
        end
        chk("fill_occ", int'(occupancy), 8);
        chk("fill_full", int'(full), 1);

        car_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            btn = logic'(i % 2);
            step();
            if (ticket_vld) pulses++;
        end
        chk("full_no_ticket", pulses, 0);
        chk("full_state_idle", int'(state), 0);
        btn = 1'b0; exit_evt = 1'b1;
        step();
        exit_evt = 1'b0;
        chk("exit_occ7", int'(occupancy), 7);
        chk("exit_full_clear", int'(full), 0);
        chk("exit_state_idle", int'(state), 0);
        step();
        chk("waiting_car_advances", int'(state), 1);
        car_in = 1'b0;
        step();

        // Bring occupancy to 3, then finish an entry together with an exit.
        exit_evt = 1'b1;
        repeat (4) step();
        exit_evt = 1'b0;
        chk("occ_down3", int'(occupancy), 3);
        entry(1'b1, 1'b1, id, gcnt);
        chk("coinc_tid", id, int'(exp_tid));
        exp_tid++;
        chk("coinc_occ3", int'(occupancy), 3);
        exit_evt = 1'b1;
        repeat (3) step();
        chk("occ_zero", int'(occupancy), 0);
        step();
        exit_evt = 1'b0;
        chk("no_underflow", int'(occupancy), 0);

        // Wrap: keep issuing until ticket 0 comes round again.
        n = 0;
        do begin
            occ_before = occupancy;
            entry(1'b1, 1'b1, id, gcnt);
            chk("wrap_tid", id, int'(exp_tid));
            exp_tid++;
            n++;
        end while (exp_tid != 8'd1 && n < 300);
        chk("wrap_reached_zero", id, 0);
        chk("wrap_occ", int'(occupancy), int'(occ_before));

        // Asynchronous reset while the barrier is open.
        entry(1'b1, 1'b0, id, gcnt);
        exp_tid++;
        chk("pre_rst_occ", int'(occupancy), 1);
        car_in = 1'b1; btn = 1'b0;
        step(); step();
        btn = 1'b1;
        n = 0;
        while (!ticket_vld && n < 10) begin step(); n++; end
        step();
        chk("pre_rst_gate", int'(gate_open), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate", int'(gate_open), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_occ", int'(occupancy), 0);
        chk("arst_tid", int'(ticket_id), 0);
        chk("arst_vld", int'(ticket_vld), 0);
        car_in = 1'b0; btn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        entry(1'b1, 1'b0, id, gcnt);
        chk("post_rst_tid", id, 0);
        chk("post_rst_occ", int'(occupancy), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
